// File: rtl/seq_fetch.sv
// SEQ fetch stage: PC register, byte-addressed instruction memory, instruction split and a
// RUN/HLT/ADR/INS status FSM. Define SEQ_FETCH_ICOUNT_EN to add the retired-fetch counter icount.
module seq_fetch #(
  parameter int unsigned IMEM_BYTES = 1024,
  parameter string       IMEM_FILE  = "imem.hex",
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] new_pc,
  output logic [63:0] pc,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [1:0]  stat
`ifdef SEQ_FETCH_ICOUNT_EN
  ,
  output logic [63:0] icount
`endif
);

  localparam int unsigned AW     = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam logic [64:0] MemEnd = 65'(IMEM_BYTES);

  // Encoding doubles as the stat code.
  typedef enum logic [1:0] {
    StRun = 2'd0,
    StHlt = 2'd1,
    StAdr = 2'd2,
    StIns = 2'd3
  } state_e;

  logic [7:0]  imem [IMEM_BYTES];

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;

  // Bytes pc..pc+9; addresses are formed in 65 bits so a fetch near 2^64 never wraps into memory.
  logic [7:0]  fbyte [10];

  for (genvar k = 0; k < 10; k++) begin : g_fetch
    logic [64:0] addr;
    assign addr     = {1'b0, pc_q} + 65'(k);
    assign fbyte[k] = (addr < MemEnd) ? imem[addr[AW-1:0]] : 8'h00;
  end

  logic [3:0]  raw_icode, raw_ifun;
  logic [3:0]  len;
  logic        icode_ok, ifun_ok, invalid, has_reg, adr_err;
  logic [63:0] const_word, raw_valc, raw_valp;

  always_comb begin
    raw_icode = fbyte[0][7:4];
    raw_ifun  = fbyte[0][3:0];
    len       = 4'd1;
    icode_ok  = 1'b1;
    ifun_ok   = (raw_ifun == 4'h0);
    case (raw_icode)
      4'h0, 4'h1, 4'h9: len = 4'd1;
      4'h2: begin
        len     = 4'd2;
        ifun_ok = (raw_ifun <= 4'd6);
      end
      4'h3, 4'h4, 4'h5: len = 4'd10;
      4'h6: begin
        len     = 4'd2;
        ifun_ok = (raw_ifun <= 4'd3);
      end
      4'h7: begin
        len     = 4'd9;
        ifun_ok = (raw_ifun <= 4'd6);
      end
      4'h8: len = 4'd9;
      4'hA, 4'hB: len = 4'd2;
      default: begin
        // Unknown icode: treated as a one-byte instruction for the address check.
        len      = 4'd1;
        icode_ok = 1'b0;
        ifun_ok  = 1'b0;
      end
    endcase

    invalid = !(icode_ok && ifun_ok);
    has_reg = (len == 4'd2) || (len == 4'd10);

    const_word = '0;
    for (int k = 0; k < 8; k++) begin
      const_word[8*k +: 8] = (len == 4'd10) ? fbyte[k+2] : fbyte[k+1];
    end
    raw_valc = ((len == 4'd10) || (len == 4'd9)) ? const_word : 64'h0;
    raw_valp = pc_q + {60'h0, len};
    adr_err  = ({1'b0, pc_q} + {61'h0, len}) > MemEnd;
  end

  // Outside RUN the stage presents a nop so decode performs no register or memory reads.
  always_comb begin
    if (state_q == StRun) begin
      icode = raw_icode;
      ifun  = raw_ifun;
      rA    = has_reg ? fbyte[1][7:4] : 4'hF;
      rB    = has_reg ? fbyte[1][3:0] : 4'hF;
      valC  = raw_valc;
      valP  = raw_valp;
    end else begin
      icode = 4'h1;
      ifun  = 4'h0;
      rA    = 4'hF;
      rB    = 4'hF;
      valC  = 64'h0;
      valP  = pc_q;
    end
  end

`ifdef SEQ_FETCH_ICOUNT_EN
  logic [63:0] icount_q, icount_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (state_q == StRun) begin
      if (adr_err) begin
        state_d = StAdr;
      end else if (invalid) begin
        state_d = StIns;
      end else if (raw_icode == 4'h0) begin
        state_d = StHlt;
      end else begin
        pc_d = new_pc;
      end
    end
`ifdef SEQ_FETCH_ICOUNT_EN
    icount_d = icount_q;
    if ((state_q == StRun) && (state_d == StRun) && (icount_q != '1)) begin
      icount_d = icount_q + 64'd1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StRun;
      pc_q     <= RESET_PC;
`ifdef SEQ_FETCH_ICOUNT_EN
      icount_q <= 64'h0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
`ifdef SEQ_FETCH_ICOUNT_EN
      icount_q <= icount_d;
`endif
    end
  end

  assign pc   = pc_q;
  assign stat = state_q;
`ifdef SEQ_FETCH_ICOUNT_EN
  assign icount = icount_q;
`endif

endmodule

// File: tb/tb_seq_fetch.sv
// Bench for seq_fetch: directed program cases with literal expectations plus randomized programs,
// all checked every cycle against an instruction-level model of the fetch stage.
module tb_seq_fetch;

  localparam int MemSize = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        follow;
  logic [63:0] user_pc, exp_valp_q, new_pc, s_new_pc;
  logic [63:0] pc, valC, valP, s_pc, s_valC, s_valP;
  logic [3:0]  icode, ifun, rA, rB, s_icode, s_ifun, s_rA, s_rB;
  logic [1:0]  stat, s_stat;
`ifdef SEQ_FETCH_ICOUNT_EN
  logic [63:0] icount, s_icount;
`endif

  assign new_pc = follow ? exp_valp_q : user_pc;

  seq_fetch #(.IMEM_BYTES(1024)) dut (
    .clk    (clk),
    .rst    (rst),
    .new_pc (new_pc),
    .pc     (pc),
    .icode  (icode),
    .ifun   (ifun),
    .rA     (rA),
    .rB     (rB),
    .valC   (valC),
    .valP   (valP),
    .stat   (stat)
`ifdef SEQ_FETCH_ICOUNT_EN
    ,
    .icount (icount)
`endif
  );

  seq_fetch #(.IMEM_BYTES(16)) dut_s (
    .clk    (clk),
    .rst    (rst),
    .new_pc (s_new_pc),
    .pc     (s_pc),
    .icode  (s_icode),
    .ifun   (s_ifun),
    .rA     (s_rA),
    .rB     (s_rB),
    .valC   (s_valC),
    .valP   (s_valP),
    .stat   (s_stat)
`ifdef SEQ_FETCH_ICOUNT_EN
    ,
    .icount (s_icount)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- instruction-level model ----------------
  logic [7:0]  m_mem [MemSize];
  logic [63:0] m_pc, m_cnt;
  int          m_st;  // 0 run, 1 halted, 2 address error, 3 bad instruction
  logic [3:0]  e_ic, e_fn, e_ra, e_rb;
  logic [63:0] e_vc, e_vp;

  function automatic int ilen(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 1;
    endcase
  endfunction

  function automatic bit iok(input logic [3:0] ic, input logic [3:0] fn);
    case (ic)
      4'h2, 4'h7:             return fn <= 4'd6;
      4'h6:                   return fn <= 4'd3;
      4'hC, 4'hD, 4'hE, 4'hF: return 1'b0;
      default:                return fn == 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] mbyte(input logic [64:0] a);
    if (a < 65'(MemSize)) return m_mem[a[9:0]];
    return 8'h00;
  endfunction

  task automatic expect_now();
    logic [7:0] b0, b1;
    int n, base;
    if (m_st != 0) begin
      e_ic = 4'h1; e_fn = 4'h0; e_ra = 4'hF; e_rb = 4'hF; e_vc = 64'h0; e_vp = m_pc;
    end else begin
      b0   = mbyte({1'b0, m_pc});
      b1   = mbyte({1'b0, m_pc} + 65'd1);
      e_ic = b0[7:4];
      e_fn = b0[3:0];
      n    = ilen(e_ic);
      e_ra = 4'hF;
      e_rb = 4'hF;
      if (n == 2 || n == 10) begin
        e_ra = b1[7:4];
        e_rb = b1[3:0];
      end
      e_vc = 64'h0;
      if (n >= 9) begin
        base = (n == 10) ? 2 : 1;
        for (int i = 7; i >= 0; i--) begin
          e_vc = (e_vc << 8) | 64'(mbyte({1'b0, m_pc} + 65'(base + i)));
        end
      end
      e_vp = m_pc + 64'(n);
    end
  endtask

  task automatic model_edge();
    logic [7:0] b0;
    bit err;
    int n;
    if (rst) begin
      m_pc = 64'h0; m_st = 0; m_cnt = 64'h0;
    end else if (m_st == 0) begin
      b0  = mbyte({1'b0, m_pc});
      n   = ilen(b0[7:4]);
      err = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (({1'b0, m_pc} + 65'(i)) >= 65'(MemSize)) err = 1'b1;
      end
      if (err) m_st = 2;
      else if (!iok(b0[7:4], b0[3:0])) m_st = 3;
      else if (b0[7:4] == 4'h0) m_st = 1;
      else begin
        m_pc = new_pc;
        if (m_cnt != '1) m_cnt = m_cnt + 64'd1;
      end
    end
  endtask

  task automatic refresh();
    expect_now();
    exp_valp_q = e_vp;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_edge();
  end

  // Every-cycle comparison, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      expect_now();
      chk("pc", pc, m_pc);
      chk("stat", 64'(stat), 64'(m_st));
      chk("icode", 64'(icode), 64'(e_ic));
      chk("ifun", 64'(ifun), 64'(e_fn));
      chk("rA", 64'(rA), 64'(e_ra));
      chk("rB", 64'(rB), 64'(e_rb));
      chk("valC", valC, e_vc);
      chk("valP", valP, e_vp);
`ifdef SEQ_FETCH_ICOUNT_EN
      chk("icount", icount, m_cnt);
`endif
      exp_valp_q = e_vp;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic put(input int a, input logic [7:0] v);
    if (a >= 0 && a < MemSize) begin
      dut.imem[a] = v;
      m_mem[a]    = v;
    end
  endtask

  task automatic begin_test();
    rst = 1'b1;
    for (int i = 0; i < MemSize; i++) put(i, 8'h00);
  endtask

  task automatic release_rst();
    #1 rst = 1'b0;
    refresh();
    chk_en = 1'b1;
    #1;
  endtask

  task automatic wait_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic load_seq1();
    put(0, 8'h30); put(1, 8'hF2); put(2, 8'h0A);
    put(10, 8'h10); put(11, 8'h00);
  endtask

  task automatic gen_stream(input int start, input int stop);
    int a, n;
    logic [3:0] ic, fn;
    a = start;
    while (a < stop) begin
      ic = 4'($urandom_range(11, 0));
      if (ic == 4'h0 && $urandom_range(3, 0) != 0) ic = 4'h1;
      if ($urandom_range(15, 0) == 0) ic = 4'($urandom_range(15, 12));
      case (ic)
        4'h2, 4'h7: fn = 4'($urandom_range(6, 0));
        4'h6:       fn = 4'($urandom_range(3, 0));
        default:    fn = 4'h0;
      endcase
      if ($urandom_range(9, 0) == 0) fn = 4'($urandom_range(15, 0));
      put(a, {ic, fn});
      n = ilen(ic);
      for (int i = 1; i < n; i++) put(a + i, 8'($urandom));
      a += n;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst      = 1'b0;
    follow   = 1'b1;
    user_pc  = 64'h0;
    s_new_pc = 64'h8;
    exp_valp_q = 64'h0;
    #1;
    for (int i = 0; i < 16; i++) dut_s.imem[i] = 8'h00;

    // Straight-line program: irmovq $10,%rdx; nop; halt.
    begin_test(); load_seq1(); release_rst();
    chk("rst_pc", pc, 64'h0);
    chk("rst_stat", 64'(stat), 64'h0);
    chk("t1_icode0", 64'(icode), 64'h3);
    chk("t1_rA0", 64'(rA), 64'hF);
    chk("t1_rB0", 64'(rB), 64'h2);
    chk("t1_valC0", valC, 64'd10);
    chk("t1_valP0", valP, 64'd10);
    wait_cyc();
    chk("t1_pc1", pc, 64'd10);
    chk("t1_icode1", 64'(icode), 64'h1);
    chk("t1_valP1", valP, 64'd11);
    wait_cyc();
    chk("t1_pc2", pc, 64'd11);
    chk("t1_icode2", 64'(icode), 64'h0);
    chk("t1_stat2", 64'(stat), 64'h0);
    wait_cyc();
    chk("t1_stat_hlt", 64'(stat), 64'h1);
    chk("t1_pc_hlt", pc, 64'd11);
    chk("t1_icode_hlt", 64'(icode), 64'h1);

    // call 0x10, ret at 0x10.
    follow = 1'b0; user_pc = 64'h10;
    begin_test(); put(0, 8'h80); put(1, 8'h10); put(16, 8'h90); release_rst();
    chk("t2_icode", 64'(icode), 64'h8);
    chk("t2_valC", valC, 64'h10);
    chk("t2_valP", valP, 64'd9);
    chk("t2_rA", 64'(rA), 64'hF);
    chk("t2_rB", 64'(rB), 64'hF);
    wait_cyc();
    chk("t2_pc", pc, 64'h10);
    chk("t2_icode_ret", 64'(icode), 64'h9);
    chk("t2_valP_ret", valP, 64'h11);

    // Same program with an OPq of undefined function.
    begin_test(); put(0, 8'h64); put(1, 8'h10); put(16, 8'h90); release_rst();
    wait_cyc();
    chk("t2b_stat", 64'(stat), 64'h3);
    chk("t2b_pc", pc, 64'h0);

    // Undefined icode: terminal INS with forced nop outputs.
    begin_test(); put(0, 8'hC0); release_rst();
    for (int i = 0; i < 6; i++) begin
      user_pc = 64'($urandom_range(255, 0));
      wait_cyc();
      chk("t3_stat", 64'(stat), 64'h3);
      chk("t3_pc", pc, 64'h0);
      chk("t3_icode", 64'(icode), 64'h1);
      chk("t3_valP", valP, 64'h0);
    end

    // subq %rdx,%rdx is legal.
    follow = 1'b1;
    begin_test(); put(0, 8'h61); put(1, 8'h22); release_rst();
    chk("t3b_ifun", 64'(ifun), 64'h1);
    chk("t3b_rA", 64'(rA), 64'h2);
    wait_cyc();
    chk("t3b_stat", 64'(stat), 64'h0);
    chk("t3b_pc", pc, 64'h2);

    // 16-byte instance: irmovq at 8 runs past the end of memory.
    begin_test();
    dut_s.imem[0] = 8'h10; dut_s.imem[8] = 8'h30; dut_s.imem[9] = 8'hF0;
    for (int i = 10; i < 16; i++) dut_s.imem[i] = 8'(i - 9);
    release_rst();
    chk("t4_s_pc0", s_pc, 64'h0);
    chk("t4_s_icode0", 64'(s_icode), 64'h1);
    wait_cyc();
    chk("t4_s_pc", s_pc, 64'h8);
    chk("t4_s_icode", 64'(s_icode), 64'h3);
    chk("t4_s_ifun", 64'(s_ifun), 64'h0);
    chk("t4_s_rA", 64'(s_rA), 64'hF);
    chk("t4_s_rB", 64'(s_rB), 64'h0);
    chk("t4_s_valC", s_valC, 64'h0000_0605_0403_0201);
    chk("t4_s_valP", s_valP, 64'd18);
    chk("t4_s_stat", 64'(s_stat), 64'h0);
    wait_cyc();
    chk("t4_s_stat_adr", 64'(s_stat), 64'h2);
    chk("t4_s_pc_adr", s_pc, 64'h8);
    chk("t4_s_valP_adr", s_valP, 64'h8);
`ifdef SEQ_FETCH_ICOUNT_EN
    chk("t4_s_icount", s_icount, 64'd1);
`endif

    // Jump to the top of the address space: no wrap-around acceptance.
    follow = 1'b0; user_pc = '1;
    begin_test(); put(0, 8'h10); release_rst();
    wait_cyc();
    chk("t4b_pc", pc, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t4b_icode", 64'(icode), 64'h0);
    chk("t4b_valP_wrap", valP, 64'h0);
    wait_cyc();
    chk("t4b_stat", 64'(stat), 64'h2);
    chk("t4b_pc_hold", pc, 64'hFFFF_FFFF_FFFF_FFFF);

    // Asynchronous reset in mid-run.
    follow = 1'b1;
    begin_test(); load_seq1(); release_rst();
    wait_cyc();
    chk("t5_pc_before", pc, 64'd10);
    rst = 1'b1;
    #1;
    chk("t5_pc_async", pc, 64'h0);
    chk("t5_stat_async", 64'(stat), 64'h0);
    chk("t5_icode_async", 64'(icode), 64'h3);
`ifdef SEQ_FETCH_ICOUNT_EN
    chk("t5_icount_rst", icount, 64'h0);
`endif
    rst = 1'b0;
    refresh();
    wait_cyc(); wait_cyc(); wait_cyc();
    chk("t5_stat_hlt", 64'(stat), 64'h1);
    chk("t5_pc_hlt", pc, 64'd11);
`ifdef SEQ_FETCH_ICOUNT_EN
    chk("t5_icount_hlt", icount, 64'd2);
`endif

    // Randomized programs with mixed sequential, jumping and out-of-range next PCs.
    for (int ep = 0; ep < 80; ep++) begin
      int post;
      int r;
      begin_test();
      gen_stream(0, 60);
      gen_stream(1008 + int'($urandom_range(7, 0)), MemSize);
      release_rst();
      post = 0;
      for (int c = 0; c < 25 && post < 3; c++) begin
        r = int'($urandom_range(9, 0));
        follow = (r < 6);
        if (r < 8) user_pc = 64'($urandom_range(63, 0));
        else if (r == 8) user_pc = 64'($urandom_range(1023, 1000));
        else user_pc = {$urandom, $urandom};
        wait_cyc();
        if (m_st != 0) post++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
